// File: rtl/array_multiplier_8bit.sv
// 8x8 unsigned array multiplier with a registered 16-bit product.
// The partial products are summed by seven rows of 8-bit ripple-carry adders
// built from explicit half-adder and full-adder cells. The result is registered
// one cycle after in_valid is sampled.

module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module array_multiplier_8bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic [15:0] P,
   output logic        out_valid
);

   // pp[i][j] = A[j] & B[i]
   logic [7:0]  pp      [8];
   // Running upper bits carried into the next row. The LSB of each row
   // retires into the product, and the row carry-out becomes the new MSB.
   logic [7:0]  upper   [7];
   logic [7:0]  row_sum [1:7];
   logic [8:1]  row_c   [1:7];
   logic [15:0] prod_comb;

   logic [15:0] p_d, p_q;
   logic        out_valid_d, out_valid_q;

   for (genvar i = 0; i < 8; i++) begin : g_pp
      assign pp[i] = A & {8{B[i]}};
   end

   assign upper[0] = {1'b0, pp[0][7:1]};

   for (genvar i = 1; i < 8; i++) begin : g_row
      half_adder u_ha (
         .a (pp[i][0]),
         .b (upper[i-1][0]),
         .s (row_sum[i][0]),
         .c (row_c[i][1])
      );
      for (genvar j = 1; j < 8; j++) begin : g_col
         full_adder u_fa (
            .a  (pp[i][j]),
            .b  (upper[i-1][j]),
            .ci (row_c[i][j]),
            .s  (row_sum[i][j]),
            .co (row_c[i][j+1])
         );
      end
      if (i < 7) begin : g_fwd
         assign upper[i] = {row_c[i][8], row_sum[i][7:1]};
      end
   end

   assign prod_comb[0]    = pp[0][0];
   for (genvar i = 1; i < 7; i++) begin : g_lsb
      assign prod_comb[i] = row_sum[i][0];
   end
   assign prod_comb[15:7] = {row_c[7][8], row_sum[7]};

   // Next-state: capture a new product when in_valid, otherwise hold P.
   always_comb begin
      p_d         = p_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         p_d         = prod_comb;
         out_valid_d = 1'b1;
      end
   end

   // Output registers with synchronous active-low reset taking priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_q         <= 16'h0000;
         out_valid_q <= 1'b0;
      end else begin
         p_q         <= p_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign P         = p_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_array_multiplier_8bit.sv
// Self-checking bench for array_multiplier_8bit: a behavioural reference model
// checked on every cycle, plus directed literal expectations.

module tb_array_multiplier_8bit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [15:0] P;
   logic        out_valid;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] exp_p;
   logic        exp_v;
   logic        model_ok = 1'b0;

   array_multiplier_8bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .P         (P),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] gp, input logic gv,
                        input logic [15:0] ep, input logic ev);
      n_tests++;
      if (gp !== ep || gv !== ev) begin
         n_fail++;
         $display("FAIL %s: got P=%h out_valid=%b, expected P=%h out_valid=%b",
                  name, gp, gv, ep, ev);
      end
   endtask

   // Reference model: plain arithmetic product, registered on the clock edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         exp_p    = 16'h0000;
         exp_v    = 1'b0;
         model_ok = 1'b1;
      end else begin
         exp_v = in_valid;
         if (in_valid) exp_p = 16'(A) * 16'(B);
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (model_ok) check("model", P, out_valid, exp_p, exp_v);
   end

   // Drive one cycle of inputs starting at a negedge; returns at the next negedge.
   task automatic apply(input logic [7:0] a, input logic [7:0] b,
                        input logic v, input logic r);
      A        = a;
      B        = b;
      in_valid = v;
      rst_n    = r;
      @(negedge clk);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      A        = 8'd0;
      B        = 8'd0;
      @(negedge clk);
      apply(8'd0, 8'd0, 1'b0, 1'b0);
      check("reset", P, out_valid, 16'h0000, 1'b0);

      apply(8'd12, 8'd2, 1'b1, 1'b1);
      check("12x2", P, out_valid, 16'h0018, 1'b1);

      apply(8'd5, 8'd6, 1'b1, 1'b1);
      check("b2b_5x6", P, out_valid, 16'h001E, 1'b1);
      apply(8'd31, 8'd3, 1'b1, 1'b1);
      check("b2b_31x3", P, out_valid, 16'h005D, 1'b1);
      apply(8'd10, 8'd10, 1'b1, 1'b1);
      check("b2b_10x10", P, out_valid, 16'h0064, 1'b1);

      for (int k = 0; k < 3; k++) begin
         apply(8'(8'd37 + k * 50), 8'(8'd200 - k * 31), 1'b0, 1'b1);
         check("idle_hold", P, out_valid, 16'h0064, 1'b0);
      end

      apply(8'd255, 8'd255, 1'b1, 1'b1);
      check("255x255", P, out_valid, 16'hFE01, 1'b1);
      apply(8'd0, 8'd255, 1'b1, 1'b1);
      check("0x255", P, out_valid, 16'h0000, 1'b1);
      apply(8'd255, 8'd0, 1'b1, 1'b1);
      check("255x0", P, out_valid, 16'h0000, 1'b1);
      apply(8'd255, 8'd1, 1'b1, 1'b1);
      check("255x1", P, out_valid, 16'h00FF, 1'b1);
      apply(8'd128, 8'd128, 1'b1, 1'b1);
      check("128x128", P, out_valid, 16'h4000, 1'b1);
      apply(8'd1, 8'd1, 1'b1, 1'b1);
      check("1x1", P, out_valid, 16'h0001, 1'b1);
      apply(8'd170, 8'd85, 1'b1, 1'b1);
      check("170x85", P, out_valid, 16'h3872, 1'b1);

      apply(8'd7, 8'd9, 1'b1, 1'b0);
      check("rst_prio_7x9", P, out_valid, 16'h0000, 1'b0);
      apply(8'd7, 8'd9, 1'b1, 1'b1);
      check("after_rst_7x9", P, out_valid, 16'h003F, 1'b1);

      // Mid-stream reset, then idle: P stays cleared.
      apply(8'd100, 8'd100, 1'b1, 1'b1);
      apply(8'd99, 8'd99, 1'b1, 1'b0);
      check("mid_rst", P, out_valid, 16'h0000, 1'b0);
      apply(8'd99, 8'd99, 1'b0, 1'b1);
      check("post_rst_idle", P, out_valid, 16'h0000, 1'b0);

      // Full edge rows: every A against 255 and every B against 255.
      for (int a = 0; a < 256; a++) apply(8'(a), 8'd255, 1'b1, 1'b1);
      for (int b = 0; b < 256; b++) apply(8'd255, 8'(b), 1'b1, 1'b1);
      // Single-bit operands exercise each array row and column in isolation.
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            apply(8'(1 << i), 8'(1 << j), 1'b1, 1'b1);

      // Randomized sweep with occasional idle cycles.
      for (int k = 0; k < 6000; k++)
         apply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 9) != 0), 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
